// File: rtl/legv8_mem_pkg.sv
// Shared types for the data-RAM initiator: access size codes, FSM states and the latched request.
package legv8_mem_pkg;

   localparam int DEPTH_DEF = 32;

   typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;

   typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RSP} state_e;

   typedef struct packed {
      logic        write;
      size_e       size;
      logic        sgn;
      logic [63:0] addr;
      logic [63:0] wdata;
   } req_t;

   // Natural alignment: the low address bits covered by the access size must be zero.
   function automatic logic misaligned(input logic [2:0] off, input size_e sz);
      case (sz)
         SZ_B:    misaligned = 1'b0;
         SZ_H:    misaligned = off[0];
         SZ_W:    misaligned = |off[1:0];
         default: misaligned = |off;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request/response handshake plus data-RAM strobes, bundled for the access unit.
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        rsp_error;
   logic [63:0] mem_address;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [63:0] mem_data_in;
   logic [63:0] mem_out;

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_out,
      output req_ready, rsp_valid, rsp_rdata, rsp_error,
             mem_address, mem_read_en, mem_write_en, mem_data_in
   );

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_out,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error,
             mem_address, mem_read_en, mem_write_en, mem_data_in
   );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extract/extend a load from a RAM word, merge store bytes into it.
module mem_lane_align
   import legv8_mem_pkg::*;
(
   input  logic [63:0] ram_word,
   input  logic [63:0] wdata,
   input  logic [2:0]  off,
   input  size_e       size,
   input  logic        sgn,
   output logic [63:0] ld_data,
   output logic [63:0] st_word
);

   logic [63:0] sh;
   logic [63:0] wsh;
   logic [7:0]  be;
   logic [7:0]  be_sh;

   assign sh    = ram_word >> {off, 3'b000};
   assign wsh   = wdata << {off, 3'b000};
   assign be_sh = be << off;

   always_comb begin
      ld_data = sh;
      be      = 8'hFF;
      case (size)
         SZ_B: begin
            ld_data = {{56{sgn & sh[7]}}, sh[7:0]};
            be      = 8'h01;
         end
         SZ_H: begin
            ld_data = {{48{sgn & sh[15]}}, sh[15:0]};
            be      = 8'h03;
         end
         SZ_W: begin
            ld_data = {{32{sgn & sh[31]}}, sh[31:0]};
            be      = 8'h0F;
         end
         default: begin
            ld_data = sh;
            be      = 8'hFF;
         end
      endcase
   end

   // Offsets are already aligned, so the shifted enable never spills past byte 7.
   for (genvar i = 0; i < 8; i++) begin : g_lane
      assign st_word[8*i +: 8] = be_sh[i] ? wsh[8*i +: 8] : ram_word[8*i +: 8];
   end

endmodule

// File: rtl/mem_access_unit.sv
// Data-RAM initiator: one access at a time, read-modify-write for sub-dword stores, error flagging.
module mem_access_unit
   import legv8_mem_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int RD_WAIT = 0
) (
   input logic              clk,
   input logic              rst_n,
   mem_access_unit_if.slave bus
);

   localparam int CW = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;

   state_e              state_q, state_d;
   req_t                req_q, req_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                ready_q, ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_error_q, rsp_error_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rd_en_q, rd_en_d;
   logic                wr_en_q, wr_en_d;
   logic [DATA_W-1:0]   din_q, din_d;

   req_t                req_in;
   logic                req_err;
   logic [DATA_W-1:0]   ld_data;
   logic [DATA_W-1:0]   st_word;

   assign req_in  = '{write: bus.req_write, size: size_e'(bus.req_size), sgn: bus.req_signed,
                      addr: bus.req_addr, wdata: bus.req_wdata};
   assign req_err = misaligned(bus.req_addr[2:0], size_e'(bus.req_size)) ||
                    (bus.req_addr[63:3] >= 61'(DEPTH));

   mem_lane_align u_align (
      .ram_word (bus.mem_out),
      .wdata    (req_q.wdata),
      .off      (req_q.addr[2:0]),
      .size     (req_q.size),
      .sgn      (req_q.sgn),
      .ld_data  (ld_data),
      .st_word  (st_word)
   );

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_error_d = rsp_error_q;
      rsp_rdata_d = rsp_rdata_q;
      rd_en_d     = 1'b0;
      wr_en_d     = 1'b0;
      din_d       = din_q;
      case (state_q)
         ST_IDLE: if (bus.req_valid && ready_q) begin
            req_d = req_in;
            if (req_err) begin
               state_d     = ST_RSP;
               rsp_valid_d = 1'b1;
               rsp_error_d = 1'b1;
               rsp_rdata_d = '0;
            end else if (bus.req_write && size_e'(bus.req_size) == SZ_D) begin
               state_d = ST_WR;
               wr_en_d = 1'b1;
               din_d   = bus.req_wdata;
            end else begin
               state_d = ST_RD;
               rd_en_d = 1'b1;
               cnt_d   = '0;
            end
         end
         // mem_out is taken on the edge that ends the last read cycle.
         ST_RD: if (cnt_q == CW'(RD_WAIT)) begin
            if (req_q.write) begin
               state_d = ST_WR;
               wr_en_d = 1'b1;
               din_d   = st_word;
            end else begin
               state_d     = ST_RSP;
               rsp_valid_d = 1'b1;
               rsp_error_d = 1'b0;
               rsp_rdata_d = ld_data;
            end
         end else begin
            cnt_d   = cnt_q + 1'b1;
            rd_en_d = 1'b1;
         end
         ST_WR: begin
            state_d     = ST_RSP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b0;
            rsp_rdata_d = '0;
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         req_q       <= '0;
         cnt_q       <= '0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= '0;
         rd_en_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         din_q       <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_rdata_q <= rsp_rdata_d;
         rd_en_q     <= rd_en_d;
         wr_en_q     <= wr_en_d;
         din_q       <= din_d;
      end
   end

   assign bus.req_ready    = ready_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_error    = rsp_error_q;
   assign bus.rsp_rdata    = rsp_rdata_q;
   assign bus.mem_read_en  = rd_en_q;
   assign bus.mem_write_en = wr_en_q;
   assign bus.mem_data_in  = din_q;
   assign bus.mem_address  = {3'b000, req_q.addr[63:3]};

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit (RD_WAIT=2) against a word-array RAM and a behavioural access model.
module tb_mem_access_unit;

   localparam int RDW = 2;

   logic clk;
   logic rst_n;
   logic init_ram;
   int   checks;
   int   failures;

   mem_access_unit_if bus();

   mem_access_unit #(.RD_WAIT(RDW)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM seen by the DUT: combinational read, write on the rising edge.
   logic [63:0] ram [0:31];
   always @(posedge clk) begin
      if (init_ram) for (int i = 0; i < 32; i++) ram[i] <= 64'(i * 100);
      else if (bus.mem_write_en && bus.mem_address < 64'd32)
         ram[bus.mem_address[4:0]] <= bus.mem_data_in;
   end
   assign bus.mem_out = (bus.mem_address < 64'd32) ? ram[bus.mem_address[4:0]] : 64'hDEAD_BEEF_DEAD_BEEF;

   // Protocol watch: strobe exclusivity, no strobes/ready in RSP, write address/data held.
   int          inv_err;
   logic        prev_wr;
   logic [63:0] prev_addr, prev_din;
   always @(negedge clk) begin
      if (!rst_n) prev_wr = 1'b0;
      else begin
         if (bus.mem_read_en && bus.mem_write_en) inv_err++;
         if (bus.rsp_valid && (bus.mem_read_en || bus.mem_write_en || bus.req_ready)) inv_err++;
         if (bus.req_ready && (bus.mem_read_en || bus.mem_write_en)) inv_err++;
         if (prev_wr && (bus.mem_address !== prev_addr || bus.mem_data_in !== prev_din)) inv_err++;
         prev_wr   = bus.mem_write_en;
         prev_addr = bus.mem_address;
         prev_din  = bus.mem_data_in;
      end
   end

   // Behavioural model of the RAM contents and of one access.
   logic [63:0] model_mem [0:31];

   function automatic logic ref_err(input logic [63:0] a, input logic [1:0] sz);
      return ((a % (64'd1 << sz)) != 64'd0) || ((a >> 3) >= 64'd32);
   endfunction

   function automatic logic [63:0] ref_load(input logic [63:0] w, input logic [2:0] off,
                                            input logic [1:0] sz, input logic sg);
      int nb = 1 << sz;
      logic [63:0] v = w >> (8 * off);
      if (nb < 8) begin
         v = v & ((64'd1 << (8 * nb)) - 64'd1);
         if (sg && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
      end
      return v;
   endfunction

   function automatic logic [63:0] ref_store(input logic [63:0] w, input logic [2:0] off,
                                             input logic [1:0] sz, input logic [63:0] wd);
      for (int b = 0; b < (1 << sz); b++) w[8*(off+b) +: 8] = wd[8*b +: 8];
      return w;
   endfunction

   function automatic int ref_lat(input logic wr, input logic [1:0] sz, input logic err);
      if (err) return 0;
      if (!wr) return RDW + 1;
      return (sz == 2'd3) ? 1 : RDW + 2;
   endfunction

   // Results of the most recent transaction.
   logic [63:0] r_data, r_maddr, r_wdin;
   logic        r_err, r_ok;
   int          r_k, r_rdc, r_wrc, r_busy, r_wait;

   task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [63:0] a, input logic [63:0] wd);
      bit done = 0;
      r_ok = 1; r_k = -1; r_rdc = 0; r_wrc = 0; r_busy = 0; r_wait = 0;
      r_data = 'x; r_err = 1'bx; r_maddr = 'x; r_wdin = 'x;
      @(negedge clk);
      bus.req_write = w; bus.req_size = sz; bus.req_signed = sg;
      bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
      while (!bus.req_ready && r_wait < 50) begin @(negedge clk); r_wait++; end
      if (bus.req_ready) begin
         @(posedge clk); #1;
         // A different request stays presented while busy; it must not be taken.
         bus.req_write = 1'b1; bus.req_size = 2'd3; bus.req_addr = 64'h0;
         bus.req_wdata = {$urandom, $urandom};
         for (int j = 0; j < 50 && !done; j++) begin
            if (j == 0) r_maddr = bus.mem_address;
            if (bus.mem_read_en) r_rdc++;
            if (bus.mem_write_en) begin r_wrc++; r_wdin = bus.mem_data_in; end
            if (bus.req_ready) r_busy++;
            if (bus.rsp_valid) begin
               r_data = bus.rsp_rdata; r_err = bus.rsp_error; r_k = j; done = 1;
               bus.req_valid = 1'b0;
            end else begin
               @(posedge clk); #1;
            end
         end
      end
      bus.req_valid = 1'b0;
      r_ok = done;
      checks++;
      if (!r_ok) begin
         failures++;
         $display("FAIL handshake_timeout addr=%h got_done=0 exp_done=1", a);
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.mem_read_en, bus.mem_write_en} !== 5'b10000) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=10000", {bus.req_ready, bus.rsp_valid, bus.rsp_error,
                  bus.mem_read_en, bus.mem_write_en});
      end
      checks++;
      if ({bus.rsp_rdata, bus.mem_address, bus.mem_data_in} !== 192'd0) begin
         failures++;
         $display("FAIL reset_data got rdata=%h addr=%h din=%h exp=0", bus.rsp_rdata, bus.mem_address, bus.mem_data_in);
      end
   endtask

   task automatic test_load_sizes();
      do_req(1'b0, 2'd3, 1'b0, 64'h28, 64'h0);
      checks++; if (r_maddr !== 64'd5) begin failures++; $display("FAIL ldur_addr got=%0d exp=5", r_maddr); end
      checks++; if (r_data !== 64'h1F4 || r_err !== 1'b0) begin failures++; $display("FAIL ldur_data got=%h err=%b exp=1f4 err=0", r_data, r_err); end
      checks++; if (r_k !== RDW + 1) begin failures++; $display("FAIL ldur_latency got=%0d exp=%0d", r_k, RDW + 1); end
      do_req(1'b0, 2'd0, 1'b0, 64'h29, 64'h0);
      checks++; if (r_data !== 64'h01) begin failures++; $display("FAIL ldurb_data got=%h exp=01", r_data); end
      do_req(1'b0, 2'd1, 1'b0, 64'h28, 64'h0);
      checks++; if (r_data !== 64'h1F4) begin failures++; $display("FAIL ldurh_data got=%h exp=1f4", r_data); end
   endtask

   task automatic test_store_merge();
      do_req(1'b1, 2'd0, 1'b0, 64'h30, 64'hFFFF_FFFF_FFFF_FF80);
      model_mem[6] = 64'h280;
      checks++; if (r_rdc !== RDW + 1 || r_wrc !== 1) begin failures++; $display("FAIL sturb_strobes got rd=%0d wr=%0d exp rd=%0d wr=1", r_rdc, r_wrc, RDW + 1); end
      checks++; if (r_wdin !== 64'h280) begin failures++; $display("FAIL sturb_merge got=%h exp=280", r_wdin); end
      checks++; if (r_k !== RDW + 2 || r_data !== 64'h0) begin failures++; $display("FAIL sturb_rsp got k=%0d rdata=%h exp k=%0d rdata=0", r_k, r_data, RDW + 2); end
      do_req(1'b0, 2'd0, 1'b1, 64'h30, 64'h0);
      checks++; if (r_data !== 64'hFFFF_FFFF_FFFF_FF80) begin failures++; $display("FAIL ldursb_data got=%h exp=ffffffffffffff80", r_data); end
      do_req(1'b0, 2'd2, 1'b1, 64'h30, 64'h0);
      checks++; if (r_data !== 64'h280) begin failures++; $display("FAIL ldursw_data got=%h exp=280", r_data); end
   endtask

   task automatic test_errors();
      do_req(1'b0, 2'd1, 1'b0, 64'h0B, 64'h0);
      checks++; if (r_err !== 1'b1 || r_k !== 0 || r_data !== 64'h0) begin failures++; $display("FAIL misalign_rsp got err=%b k=%0d rdata=%h exp err=1 k=0 rdata=0", r_err, r_k, r_data); end
      checks++; if (r_rdc + r_wrc !== 0) begin failures++; $display("FAIL misalign_strobes got=%0d exp=0", r_rdc + r_wrc); end
      do_req(1'b1, 2'd3, 1'b0, 64'h100, 64'h1234);
      checks++; if (r_err !== 1'b1 || r_k !== 0 || r_rdc + r_wrc !== 0) begin failures++; $display("FAIL range_rsp got err=%b k=%0d strobes=%0d exp err=1 k=0 strobes=0", r_err, r_k, r_rdc + r_wrc); end
   endtask

   task automatic test_rd_wait();
      do_req(1'b0, 2'd3, 1'b0, 64'hF8, 64'h0);
      checks++; if (r_rdc !== RDW + 1 || r_data !== 64'd3100) begin failures++; $display("FAIL rdwait_hold got rd=%0d data=%0d exp rd=%0d data=3100", r_rdc, r_data, RDW + 1); end
      do_req(1'b1, 2'd3, 1'b0, 64'h40, 64'hA5A5_0000_1111_2222);
      model_mem[8] = 64'hA5A5_0000_1111_2222;
      checks++; if (r_rdc !== 0 || r_wrc !== 1 || r_k !== 1 || r_wdin !== 64'hA5A5_0000_1111_2222) begin failures++; $display("FAIL stur_dword got rd=%0d wr=%0d k=%0d din=%h exp rd=0 wr=1 k=1 din=a5a5000011112222", r_rdc, r_wrc, r_k, r_wdin); end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 6; n++) begin
         logic [63:0] a = {56'd0, 5'(n * 3), 3'b000};
         do_req(1'b0, 2'd3, 1'b0, a, 64'h0);
         checks++; if (r_busy !== 0) begin failures++; $display("FAIL b2b_ready_busy n=%0d got=%0d exp=0", n, r_busy); end
         if (n > 0) begin
            checks++; if (r_wait !== 1) begin failures++; $display("FAIL b2b_accept_gap n=%0d got=%0d exp=1", n, r_wait); end
         end
         checks++; if (r_data !== model_mem[n*3]) begin failures++; $display("FAIL b2b_data n=%0d got=%h exp=%h", n, r_data, model_mem[n*3]); end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         logic        w  = 1'($urandom);
         logic [1:0]  sz = 2'($urandom);
         logic        sg = 1'($urandom);
         logic [2:0]  off = 3'($urandom);
         logic [63:0] idx = 64'($urandom_range(0, 35));
         logic [63:0] wd = {$urandom, $urandom};
         logic [63:0] a, exp_data, exp_din;
         logic        exp_err;
         if ($urandom_range(0, 3) != 0) off = off & ~3'((1 << sz) - 1);
         a = {idx[60:0], off};
         exp_err  = ref_err(a, sz);
         exp_data = (exp_err || w) ? 64'h0 : ref_load(model_mem[idx[4:0]], off, sz, sg);
         exp_din  = (sz == 2'd3) ? wd : ref_store(model_mem[idx[4:0]], off, sz, wd);
         do_req(w, sz, sg, a, wd);
         if (w && !exp_err) model_mem[idx[4:0]] = exp_din;
         checks++; if (r_err !== exp_err || r_data !== exp_data) begin failures++; $display("FAIL rand_rsp n=%0d a=%h sz=%0d w=%b got err=%b data=%h exp err=%b data=%h", n, a, sz, w, r_err, r_data, exp_err, exp_data); end
         checks++; if (r_k !== ref_lat(w, sz, exp_err)) begin failures++; $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, r_k, ref_lat(w, sz, exp_err)); end
         checks++; if (r_maddr !== (a >> 3)) begin failures++; $display("FAIL rand_addr n=%0d got=%h exp=%h", n, r_maddr, a >> 3); end
         checks++;
         if (r_wrc !== ((w && !exp_err) ? 1 : 0) || (w && !exp_err && r_wdin !== exp_din)) begin
            failures++; $display("FAIL rand_write n=%0d got wr=%0d din=%h exp din=%h", n, r_wrc, r_wdin, exp_din);
         end
      end
   endtask

   task automatic test_reset_midop();
      int rsp_seen = 0;
      @(negedge clk);
      bus.req_write = 1'b1; bus.req_size = 2'd3; bus.req_signed = 1'b0;
      bus.req_addr = 64'h08; bus.req_wdata = 64'h55; bus.req_valid = 1'b1;
      for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      checks++; if (bus.mem_write_en !== 1'b1) begin failures++; $display("FAIL midop_in_wr got=%b exp=1", bus.mem_write_en); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.mem_write_en !== 1'b0 || bus.mem_read_en !== 1'b0) begin failures++; $display("FAIL midop_strobes got wr=%b rd=%b exp 0 0", bus.mem_write_en, bus.mem_read_en); end
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin @(negedge clk); if (bus.rsp_valid) rsp_seen++; end
      checks++; if (rsp_seen !== 0 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL midop_after got rsp=%0d ready=%b exp rsp=0 ready=1", rsp_seen, bus.req_ready); end
      checks++; if (ram[1] !== 64'd100) begin failures++; $display("FAIL midop_ram got=%h exp=64", ram[1]); end
   endtask

   task automatic test_memory();
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (ram[i] !== model_mem[i]) begin failures++; $display("FAIL ram_word i=%0d got=%h exp=%h", i, ram[i], model_mem[i]); end
      end
   endtask

   task automatic test_invariants();
      checks++;
      if (inv_err !== 0) begin failures++; $display("FAIL protocol_invariants got=%0d exp=0", inv_err); end
   endtask

   initial begin
      checks = 0; failures = 0; inv_err = 0; prev_wr = 1'b0;
      rst_n = 1'b0; init_ram = 1'b1;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
      bus.req_addr = 64'h0; bus.req_wdata = 64'h0;
      for (int i = 0; i < 32; i++) model_mem[i] = 64'(i * 100);
      repeat (2) @(posedge clk);
      @(negedge clk);
      test_reset();
      init_ram = 1'b0;
      rst_n = 1'b1;
      test_load_sizes();
      test_store_merge();
      test_errors();
      test_rd_wait();
      test_back_to_back();
      test_random();
      test_reset_midop();
      test_memory();
      test_invariants();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
